// File: rtl/opcodes.sv
// Shared core definitions: ALU function codes, flag bit positions and the
// multiply sequencer state names used by the core controller and benches.
`ifndef FLAGS_C
`define FLAGS_C 1
`endif

package opcodes;

   typedef enum logic [3:0] {
      FnNOP = 4'h0,
      FnA   = 4'h1,
      FnB   = 4'h2,
      FnADD = 4'h3,
      FnSUB = 4'h4,
      FnAND = 4'h5,
      FnOR  = 4'h6,
      FnXOR = 4'h7
   } alu_functions_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_t;

   localparam int ALU_FLAG_BITS = 4;

endpackage

// File: rtl/mult_seq.sv
// Shift-and-add 16x16->32 multiply sequencer that borrows the shared ALU one
// iteration per granted cycle; product lives in {acc_hi, acc_lo}.
//
//   state | meaning
//   IDLE  | waiting for Start; product registers hold the last result
//   RUN   | requesting the ALU; one iteration per cycle with AluGnt
//   DONE  | one-cycle Done pulse, product valid
module mult_seq
   import opcodes::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                 Clock,
   input  logic                 nReset,
   input  logic                 Start,
   input  logic [WIDTH-1:0]     Multiplicand,
   input  logic [WIDTH-1:0]     Multiplier,
   output logic                 Busy,
   output logic                 Done,
   output logic [WIDTH-1:0]     ProdHi,
   output logic [WIDTH-1:0]     ProdLo,
   output logic                 AluReq,
   input  logic                 AluGnt,
   output alu_functions_t       AluOp,
   output logic [WIDTH-1:0]     AluOp1,
   output logic [WIDTH-1:0]     AluOp2,
   input  logic [WIDTH-1:0]     AluResult,
   input  logic [ALU_FLAG_BITS-1:0] AluFlags
);

   localparam logic [4:0] LAST_ITER = 5'(WIDTH - 1);

   mult_state_t      state;
   mult_state_t      state_nxt;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] mcand;
   logic [4:0]       count;
   logic             iterate;
   logic             unused_flags;

   assign iterate      = (state == RUN) && AluGnt;
   assign unused_flags = &{1'b0, AluFlags};

   always_ff @(posedge Clock) begin
      if (!nReset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (Start) state_nxt = RUN;
         RUN:     if (iterate && (count == LAST_ITER)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      Busy   = 1'b0;
      Done   = 1'b0;
      AluReq = 1'b0;
      AluOp  = FnNOP;
      AluOp1 = '0;
      AluOp2 = '0;
      case (state)
         RUN: begin
            Busy   = 1'b1;
            AluReq = 1'b1;
            if (AluGnt) begin
               AluOp  = acc_lo[0] ? FnADD : FnA;
               AluOp1 = acc_hi;
               AluOp2 = mcand;
            end
         end
         DONE: begin
            Busy = 1'b1;
            Done = 1'b1;
         end
         default: ;
      endcase
   end

   // Carry-in at the top of acc_hi keeps each partial sum exact.
   always_ff @(posedge Clock) begin
      if (!nReset) begin
         acc_hi <= '0;
         acc_lo <= '0;
         mcand  <= '0;
         count  <= '0;
      end else if ((state == IDLE) && Start) begin
         acc_hi <= '0;
         acc_lo <= Multiplier;
         mcand  <= Multiplicand;
         count  <= '0;
      end else if (iterate) begin
         acc_hi <= {AluFlags[`FLAGS_C], AluResult[WIDTH-1:1]};
         acc_lo <= {AluResult[0], acc_lo[WIDTH-1:1]};
         count  <= count + 5'd1;
      end
   end

   assign ProdHi = acc_hi;
   assign ProdLo = acc_lo;

endmodule
